// File: rtl/rs_pkg.sv
// Shared opcode map and default sizing for the dual-queue reservation station.
package rs_pkg;

   localparam int XLEN_D = 32;
   localparam int TAG_W_D = 3;
   localparam int OP_W_D = 5;
   localparam int ALU_DEPTH_D = 4;
   localparam int MEM_DEPTH_D = 4;
   localparam int CDB_N_D = 2;
   localparam int MEM_IN_ORDER_D = 1;

   localparam logic [4:0] ADD = 5'h00;
   localparam logic [4:0] SUB = 5'h01;
   localparam logic [4:0] SLL = 5'h02;
   localparam logic [4:0] SLT = 5'h03;
   localparam logic [4:0] SLTU = 5'h04;
   localparam logic [4:0] XOR = 5'h05;
   localparam logic [4:0] SRL = 5'h06;
   localparam logic [4:0] SRA = 5'h07;
   localparam logic [4:0] OR = 5'h08;
   localparam logic [4:0] AND = 5'h09;
   localparam logic [4:0] ADDI = 5'h0a;
   localparam logic [4:0] SLTI = 5'h0b;
   localparam logic [4:0] XORI = 5'h0c;
   localparam logic [4:0] ORI = 5'h0d;
   localparam logic [4:0] ANDI = 5'h0e;
   localparam logic [4:0] LUI = 5'h0f;
   localparam logic [4:0] AUIPC = 5'h10;
   localparam logic [4:0] JAL = 5'h11;
   localparam logic [4:0] LB = 5'h12;
   localparam logic [4:0] LH = 5'h13;
   localparam logic [4:0] LW = 5'h14;
   localparam logic [4:0] LBU = 5'h15;
   localparam logic [4:0] LHU = 5'h16;
   localparam logic [4:0] SB = 5'h17;
   localparam logic [4:0] SH = 5'h18;
   localparam logic [4:0] SW = 5'h19;
   localparam logic [4:0] BEQ = 5'h1a;
   localparam logic [4:0] BNE = 5'h1b;
   localparam logic [4:0] BLT = 5'h1c;
   localparam logic [4:0] BGE = 5'h1d;
   localparam logic [4:0] BLTU = 5'h1e;
   localparam logic [4:0] NOP = 5'h1f;

   function automatic logic is_mem_op(input logic [31:0] op);
      return (op >= 32'(LB)) && (op <= 32'(SW));
   endfunction

endpackage

// File: rtl/rs_dual_queue_if.sv
// Dispatch, CDB and issue bundle between rename, the RS and the units.
interface rs_dual_queue_if
   import rs_pkg::*;
#(
   parameter int XLEN = XLEN_D,
   parameter int TAG_W = TAG_W_D,
   parameter int OP_W = OP_W_D,
   parameter int CDB_N = CDB_N_D,
   parameter int ALU_DEPTH = ALU_DEPTH_D,
   parameter int MEM_DEPTH = MEM_DEPTH_D
);
   localparam int ACW = $clog2(ALU_DEPTH + 1);
   localparam int MCW = $clog2(MEM_DEPTH + 1);

   logic flush;
   logic disp_valid;
   logic disp_ready;
   logic [OP_W-1:0] disp_op;
   logic [TAG_W-1:0] disp_des;
   logic [TAG_W-1:0] disp_q1;
   logic [TAG_W-1:0] disp_q2;
   logic [XLEN-1:0] disp_v1;
   logic [XLEN-1:0] disp_v2;
   logic [XLEN-1:0] disp_imm;
   logic disp_is_branch;
   logic [CDB_N-1:0] cdb_valid;
   logic [CDB_N*TAG_W-1:0] cdb_tag;
   logic [CDB_N*XLEN-1:0] cdb_data;
   logic alu_valid;
   logic alu_ready;
   logic [OP_W-1:0] alu_op;
   logic [TAG_W-1:0] alu_des;
   logic [XLEN-1:0] alu_v1;
   logic [XLEN-1:0] alu_v2;
   logic alu_is_branch;
   logic mem_valid;
   logic mem_ready;
   logic [OP_W-1:0] mem_op;
   logic [TAG_W-1:0] mem_des;
   logic [XLEN-1:0] mem_v1;
   logic [XLEN-1:0] mem_v2;
   logic [XLEN-1:0] mem_imm;
   logic [ACW-1:0] alu_count;
   logic [MCW-1:0] mem_count;

   modport master (
      output flush, disp_valid, disp_op, disp_des, disp_q1, disp_q2,
      output disp_v1, disp_v2, disp_imm, disp_is_branch,
      output cdb_valid, cdb_tag, cdb_data, alu_ready, mem_ready,
      input disp_ready, alu_valid, alu_op, alu_des, alu_v1, alu_v2,
      input alu_is_branch, mem_valid, mem_op, mem_des, mem_v1, mem_v2,
      input mem_imm, alu_count, mem_count
   );

   modport slave (
      input flush, disp_valid, disp_op, disp_des, disp_q1, disp_q2,
      input disp_v1, disp_v2, disp_imm, disp_is_branch,
      input cdb_valid, cdb_tag, cdb_data, alu_ready, mem_ready,
      output disp_ready, alu_valid, alu_op, alu_des, alu_v1, alu_v2,
      output alu_is_branch, mem_valid, mem_op, mem_des, mem_v1, mem_v2,
      output mem_imm, alu_count, mem_count
   );

endinterface

// File: rtl/rs_queue.sv
// Collapsing wait queue with CDB wakeup, oldest-first select and one issue register.
module rs_queue #(
   parameter int DEPTH = 4,
   parameter int IN_ORDER = 0,
   parameter int HAS_IMM = 0,
   parameter int XLEN = 32,
   parameter int TAG_W = 3,
   parameter int OP_W = 5,
   parameter int CDB_N = 2,
   localparam int CW = $clog2(DEPTH + 1),
   localparam int IW = $clog2(DEPTH)
) (
   input  logic clk,
   input  logic rst,
   input  logic flush_i,
   input  logic push_i,
   input  logic [OP_W-1:0] op_i,
   input  logic [TAG_W-1:0] des_i,
   input  logic [TAG_W-1:0] q1_i,
   input  logic [TAG_W-1:0] q2_i,
   input  logic [XLEN-1:0] v1_i,
   input  logic [XLEN-1:0] v2_i,
   input  logic [XLEN-1:0] imm_i,
   input  logic br_i,
   input  logic [CDB_N-1:0] cdb_valid_i,
   input  logic [CDB_N*TAG_W-1:0] cdb_tag_i,
   input  logic [CDB_N*XLEN-1:0] cdb_data_i,
   output logic full_o,
   output logic [CW-1:0] count_o,
   output logic iss_valid_o,
   input  logic iss_ready_i,
   output logic [OP_W-1:0] iss_op_o,
   output logic [TAG_W-1:0] iss_des_o,
   output logic [XLEN-1:0] iss_v1_o,
   output logic [XLEN-1:0] iss_v2_o,
   output logic [XLEN-1:0] iss_imm_o,
   output logic iss_br_o
);

   logic [CW-1:0] cnt_q, cnt_d, cnt_r;
   logic [OP_W-1:0] op_q [DEPTH], op_d [DEPTH];
   logic [TAG_W-1:0] des_q [DEPTH], des_d [DEPTH];
   logic [TAG_W-1:0] q1_q [DEPTH], q1_d [DEPTH];
   logic [TAG_W-1:0] q2_q [DEPTH], q2_d [DEPTH];
   logic [XLEN-1:0] v1_q [DEPTH], v1_d [DEPTH];
   logic [XLEN-1:0] v2_q [DEPTH], v2_d [DEPTH];
   logic [XLEN-1:0] imm_q [DEPTH], imm_d [DEPTH];
   logic br_q [DEPTH], br_d [DEPTH];

   logic iv_q, iv_d, ibr_q, ibr_d;
   logic [OP_W-1:0] iop_q, iop_d;
   logic [TAG_W-1:0] ides_q, ides_d;
   logic [XLEN-1:0] iv1_q, iv1_d, iv2_q, iv2_d, iimm_q, iimm_d;

   logic [DEPTH-1:0] elig;
   logic sel_ok, take;
   logic [IW-1:0] sel_idx;
   logic [XLEN:0] bp1, bp2;

   // {hit, data}; lowest matching channel wins, tag 0 never matches
   function automatic logic [XLEN:0] snoop(input logic [TAG_W-1:0] t);
      logic [XLEN:0] r;
      r = '0;
      for (int c = CDB_N - 1; c >= 0; c--)
         if (t != '0 && cdb_valid_i[c] && cdb_tag_i[c*TAG_W +: TAG_W] == t)
            r = {1'b1, cdb_data_i[c*XLEN +: XLEN]};
      return r;
   endfunction

   assign bp1 = snoop(q1_i);
   assign bp2 = snoop(q2_i);

   always_comb begin
      elig = '0;
      for (int i = 0; i < DEPTH; i++)
         elig[i] = (CW'(i) < cnt_q) && q1_q[i] == '0 && q2_q[i] == '0;
   end

   always_comb begin
      sel_ok = 1'b0;
      sel_idx = '0;
      if (IN_ORDER != 0) begin
         sel_ok = elig[0];
      end else begin
         for (int i = DEPTH - 1; i >= 0; i--)
            if (elig[i]) begin
               sel_ok = 1'b1;
               sel_idx = IW'(i);
            end
      end
   end

   always_comb begin
      take = sel_ok && (!iv_q || iss_ready_i);
      cnt_r = cnt_q - CW'(take);
      cnt_d = cnt_r + CW'(push_i);
      iv_d = iv_q;
      iop_d = iop_q;
      ides_d = ides_q;
      iv1_d = iv1_q;
      iv2_d = iv2_q;
      iimm_d = iimm_q;
      ibr_d = ibr_q;
      if (take) begin
         iv_d = 1'b1;
         iop_d = op_q[sel_idx];
         ides_d = des_q[sel_idx];
         iv1_d = v1_q[sel_idx];
         iv2_d = v2_q[sel_idx];
         iimm_d = (HAS_IMM != 0) ? imm_q[sel_idx] : '0;
         ibr_d = br_q[sel_idx];
      end else if (iss_ready_i) begin
         iv_d = 1'b0;
      end
      for (int i = 0; i < DEPTH; i++) begin
         logic [IW-1:0] s;
         logic [XLEN:0] w1, w2;
         // younger entries slide down over the one leaving
         s = (take && IW'(i) >= sel_idx && i < DEPTH - 1) ? IW'(i + 1) : IW'(i);
         op_d[i] = op_q[s];
         des_d[i] = des_q[s];
         imm_d[i] = imm_q[s];
         br_d[i] = br_q[s];
         w1 = snoop(q1_q[s]);
         w2 = snoop(q2_q[s]);
         q1_d[i] = w1[XLEN] ? '0 : q1_q[s];
         v1_d[i] = w1[XLEN] ? w1[XLEN-1:0] : v1_q[s];
         q2_d[i] = w2[XLEN] ? '0 : q2_q[s];
         v2_d[i] = w2[XLEN] ? w2[XLEN-1:0] : v2_q[s];
         if (push_i && CW'(i) == cnt_r) begin
            op_d[i] = op_i;
            des_d[i] = des_i;
            imm_d[i] = imm_i;
            br_d[i] = br_i;
            q1_d[i] = bp1[XLEN] ? '0 : q1_i;
            v1_d[i] = bp1[XLEN] ? bp1[XLEN-1:0] : v1_i;
            q2_d[i] = bp2[XLEN] ? '0 : q2_i;
            v2_d[i] = bp2[XLEN] ? bp2[XLEN-1:0] : v2_i;
         end
      end
      if (flush_i) begin
         cnt_d = '0;
         iv_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
         iv_q <= 1'b0;
         iop_q <= '1;
         ides_q <= '0;
         iv1_q <= '0;
         iv2_q <= '0;
         iimm_q <= '0;
         ibr_q <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            op_q[i] <= '0;
            des_q[i] <= '0;
            q1_q[i] <= '0;
            q2_q[i] <= '0;
            v1_q[i] <= '0;
            v2_q[i] <= '0;
            imm_q[i] <= '0;
            br_q[i] <= 1'b0;
         end
      end else begin
         cnt_q <= cnt_d;
         iv_q <= iv_d;
         iop_q <= iop_d;
         ides_q <= ides_d;
         iv1_q <= iv1_d;
         iv2_q <= iv2_d;
         iimm_q <= iimm_d;
         ibr_q <= ibr_d;
         op_q <= op_d;
         des_q <= des_d;
         q1_q <= q1_d;
         q2_q <= q2_d;
         v1_q <= v1_d;
         v2_q <= v2_d;
         imm_q <= imm_d;
         br_q <= br_d;
      end
   end

   assign full_o = (cnt_q == CW'(DEPTH));
   assign count_o = cnt_q;
   assign iss_valid_o = iv_q;
   assign iss_op_o = iop_q;
   assign iss_des_o = ides_q;
   assign iss_v1_o = iv1_q;
   assign iss_v2_o = iv2_q;
   assign iss_imm_o = iimm_q;
   assign iss_br_o = ibr_q;

endmodule

// File: rtl/rs_dual_queue.sv
// Reservation station top: classifies dispatched ops into the ALU or memory queue.
module rs_dual_queue
   import rs_pkg::*;
#(
   parameter int XLEN = XLEN_D,
   parameter int TAG_W = TAG_W_D,
   parameter int OP_W = OP_W_D,
   parameter int ALU_DEPTH = ALU_DEPTH_D,
   parameter int MEM_DEPTH = MEM_DEPTH_D,
   parameter int CDB_N = CDB_N_D,
   parameter int MEM_IN_ORDER = MEM_IN_ORDER_D
) (
   input logic clk,
   input logic rst,
   rs_dual_queue_if.slave bus
);

   logic is_mem, acc, alu_full, mem_full;
   logic mem_br_unused;
   logic [XLEN-1:0] alu_imm_unused;

   assign is_mem = is_mem_op(32'(bus.disp_op));
   assign bus.disp_ready = !bus.flush && (is_mem ? !mem_full : !alu_full);
   // NOP completes the handshake but is dropped
   assign acc = bus.disp_valid && bus.disp_ready && bus.disp_op != '1;

   rs_queue #(
      .DEPTH(ALU_DEPTH), .IN_ORDER(0), .HAS_IMM(0), .XLEN(XLEN),
      .TAG_W(TAG_W), .OP_W(OP_W), .CDB_N(CDB_N)
   ) u_alu (
      .clk(clk), .rst(rst), .flush_i(bus.flush), .push_i(acc && !is_mem),
      .op_i(bus.disp_op), .des_i(bus.disp_des),
      .q1_i(bus.disp_q1), .q2_i(bus.disp_q2),
      .v1_i(bus.disp_v1), .v2_i(bus.disp_v2),
      .imm_i(bus.disp_imm), .br_i(bus.disp_is_branch),
      .cdb_valid_i(bus.cdb_valid), .cdb_tag_i(bus.cdb_tag),
      .cdb_data_i(bus.cdb_data),
      .full_o(alu_full), .count_o(bus.alu_count),
      .iss_valid_o(bus.alu_valid), .iss_ready_i(bus.alu_ready),
      .iss_op_o(bus.alu_op), .iss_des_o(bus.alu_des),
      .iss_v1_o(bus.alu_v1), .iss_v2_o(bus.alu_v2),
      .iss_imm_o(alu_imm_unused), .iss_br_o(bus.alu_is_branch)
   );

   rs_queue #(
      .DEPTH(MEM_DEPTH), .IN_ORDER(MEM_IN_ORDER), .HAS_IMM(1), .XLEN(XLEN),
      .TAG_W(TAG_W), .OP_W(OP_W), .CDB_N(CDB_N)
   ) u_mem (
      .clk(clk), .rst(rst), .flush_i(bus.flush), .push_i(acc && is_mem),
      .op_i(bus.disp_op), .des_i(bus.disp_des),
      .q1_i(bus.disp_q1), .q2_i(bus.disp_q2),
      .v1_i(bus.disp_v1), .v2_i(bus.disp_v2),
      .imm_i(bus.disp_imm), .br_i(bus.disp_is_branch),
      .cdb_valid_i(bus.cdb_valid), .cdb_tag_i(bus.cdb_tag),
      .cdb_data_i(bus.cdb_data),
      .full_o(mem_full), .count_o(bus.mem_count),
      .iss_valid_o(bus.mem_valid), .iss_ready_i(bus.mem_ready),
      .iss_op_o(bus.mem_op), .iss_des_o(bus.mem_des),
      .iss_v1_o(bus.mem_v1), .iss_v2_o(bus.mem_v2),
      .iss_imm_o(bus.mem_imm), .iss_br_o(mem_br_unused)
   );

endmodule

// File: tb/tb_rs_dual_queue.sv
// Directed and random checks of rs_dual_queue against a queue-based reference model.
module tb_rs_dual_queue;
   import rs_pkg::*;

   localparam int XL = 32;
   localparam int TW = 3;
   localparam int OW = 5;
   localparam int CN = 2;
   localparam int AD = 4;
   localparam int MD = 4;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   rs_dual_queue_if #(
      .XLEN(XL), .TAG_W(TW), .OP_W(OW), .CDB_N(CN),
      .ALU_DEPTH(AD), .MEM_DEPTH(MD)
   ) bus ();

   rs_dual_queue #(
      .XLEN(XL), .TAG_W(TW), .OP_W(OW), .ALU_DEPTH(AD),
      .MEM_DEPTH(MD), .CDB_N(CN), .MEM_IN_ORDER(1)
   ) dut (
      .clk(clk), .rst(rst), .bus(bus)
   );

   typedef struct packed {
      logic [4:0] op;
      logic [2:0] des;
      logic [2:0] q1;
      logic [2:0] q2;
      logic [31:0] v1;
      logic [31:0] v2;
      logic [31:0] imm;
      logic br;
   } ent_t;

   ent_t aq[$];
   ent_t mq[$];
   ent_t lq[$];
   logic iv[2];
   ent_t iss[2];
   int total = 0;
   int bad = 0;

   task automatic chk(input string tag, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      assert (act === exp)
      else begin
         bad++;
         $error("FAIL %s: got %0h want %0h", tag, act, exp);
      end
   endtask

   function automatic logic mem_class(input logic [4:0] op);
      return op >= 5'h12 && op <= 5'h19;
   endfunction

   // applies the current CDB broadcast to one operand slot
   task automatic wake(inout logic [2:0] t, inout logic [31:0] v);
      for (int c = 0; c < CN; c++)
         if (t != 3'd0 && bus.cdb_valid[c] && bus.cdb_tag[c*TW +: TW] == t) begin
            v = bus.cdb_data[c*XL +: XL];
            t = 3'd0;
         end
   endtask

   task automatic model_unit(input int u, input logic acc, input logic rdy);
      ent_t e;
      int sel;
      logic take;
      if (u == 0) lq = aq;
      else lq = mq;
      if (bus.flush) begin
         lq.delete();
         iv[u] = 1'b0;
      end else begin
         sel = -1;
         for (int i = 0; i < lq.size(); i++)
            if (sel < 0 && lq[i].q1 == 3'd0 && lq[i].q2 == 3'd0 && (u == 0 || i == 0))
               sel = i;
         take = (sel >= 0) && (!iv[u] || rdy);
         if (take) begin
            iss[u] = lq[sel];
            iv[u] = 1'b1;
            lq.delete(sel);
         end else if (rdy) begin
            iv[u] = 1'b0;
         end
         for (int i = 0; i < lq.size(); i++) begin
            e = lq[i];
            wake(e.q1, e.v1);
            wake(e.q2, e.v2);
            lq[i] = e;
         end
         if (acc) begin
            e.op = bus.disp_op;
            e.des = bus.disp_des;
            e.q1 = bus.disp_q1;
            e.q2 = bus.disp_q2;
            e.v1 = bus.disp_v1;
            e.v2 = bus.disp_v2;
            e.imm = bus.disp_imm;
            e.br = bus.disp_is_branch;
            wake(e.q1, e.v1);
            wake(e.q2, e.v2);
            lq.push_back(e);
         end
      end
      if (u == 0) aq = lq;
      else mq = lq;
   endtask

   task automatic check_outputs();
      chk("alu_count", 32'(bus.alu_count), 32'(aq.size()));
      chk("mem_count", 32'(bus.mem_count), 32'(mq.size()));
      chk("alu_valid", 32'(bus.alu_valid), 32'(iv[0]));
      chk("mem_valid", 32'(bus.mem_valid), 32'(iv[1]));
      if (iv[0]) begin
         chk("alu_op", 32'(bus.alu_op), 32'(iss[0].op));
         chk("alu_des", 32'(bus.alu_des), 32'(iss[0].des));
         chk("alu_v1", bus.alu_v1, iss[0].v1);
         chk("alu_v2", bus.alu_v2, iss[0].v2);
         chk("alu_br", 32'(bus.alu_is_branch), 32'(iss[0].br));
      end
      if (iv[1]) begin
         chk("mem_op", 32'(bus.mem_op), 32'(iss[1].op));
         chk("mem_des", 32'(bus.mem_des), 32'(iss[1].des));
         chk("mem_v1", bus.mem_v1, iss[1].v1);
         chk("mem_v2", bus.mem_v2, iss[1].v2);
         chk("mem_imm", bus.mem_imm, iss[1].imm);
      end
   endtask

   // one clock: check dispatch ready, advance model, compare after the edge
   task automatic step();
      logic m, er, acc;
      #1;
      m = mem_class(bus.disp_op);
      er = !bus.flush && (m ? mq.size() < MD : aq.size() < AD);
      chk("disp_ready", 32'(bus.disp_ready), 32'(er));
      acc = bus.disp_valid && er && bus.disp_op != 5'h1f;
      model_unit(0, acc && !m, bus.alu_ready);
      model_unit(1, acc && m, bus.mem_ready);
      @(posedge clk);
      #1;
      check_outputs();
   endtask

   task automatic idle();
      bus.disp_valid = 1'b0;
      bus.cdb_valid = '0;
      bus.cdb_tag = '0;
      bus.cdb_data = '0;
   endtask

   task automatic disp(input logic [4:0] op, input logic [2:0] des,
                       input logic [2:0] q1, input logic [2:0] q2,
                       input logic [31:0] v1, input logic [31:0] v2,
                       input logic [31:0] imm);
      bus.disp_valid = 1'b1;
      bus.disp_op = op;
      bus.disp_des = des;
      bus.disp_q1 = q1;
      bus.disp_q2 = q2;
      bus.disp_v1 = v1;
      bus.disp_v2 = v2;
      bus.disp_imm = imm;
      bus.disp_is_branch = op >= BEQ && op <= BLTU;
   endtask

   task automatic cdb(input int ch, input logic [2:0] tag, input logic [31:0] d);
      bus.cdb_valid[ch] = 1'b1;
      bus.cdb_tag[ch*TW +: TW] = tag;
      bus.cdb_data[ch*XL +: XL] = d;
   endtask

   initial begin
      rst = 1'b1;
      bus.flush = 1'b0;
      bus.alu_ready = 1'b1;
      bus.mem_ready = 1'b1;
      idle();
      disp(ADD, 3'd0, 3'd0, 3'd0, 32'd0, 32'd0, 32'd0);
      bus.disp_valid = 1'b0;
      iv[0] = 1'b0;
      iv[1] = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_alu_valid", 32'(bus.alu_valid), 32'd0);
      chk("rst_mem_valid", 32'(bus.mem_valid), 32'd0);
      chk("rst_alu_op", 32'(bus.alu_op), 32'h1f);
      chk("rst_mem_op", 32'(bus.mem_op), 32'h1f);
      chk("rst_alu_count", 32'(bus.alu_count), 32'd0);
      chk("rst_mem_count", 32'(bus.mem_count), 32'd0);
      chk("rst_alu_v1", bus.alu_v1, 32'd0);
      chk("rst_mem_imm", bus.mem_imm, 32'd0);
      rst = 1'b0;

      // ready ADD issues one cycle after acceptance
      disp(ADD, 3'd3, 3'd0, 3'd0, 32'd5, 32'd7, 32'd0);
      step();
      idle();
      step();
      chk("p1_valid", 32'(bus.alu_valid), 32'd1);
      chk("p1_v1", bus.alu_v1, 32'd5);
      chk("p1_v2", bus.alu_v2, 32'd7);
      chk("p1_des", 32'(bus.alu_des), 32'd3);
      step();
      chk("p1_low", 32'(bus.alu_valid), 32'd0);

      // SUB waits on tag 2, woken by channel 1
      disp(SUB, 3'd4, 3'd2, 3'd0, 32'd0, 32'd9, 32'd0);
      step();
      idle();
      step();
      chk("p2_wait", 32'(bus.alu_valid), 32'd0);
      cdb(1, 3'd2, 32'h10);
      step();
      idle();
      chk("p2_woken", 32'(bus.alu_valid), 32'd0);
      step();
      chk("p2_valid", 32'(bus.alu_valid), 32'd1);
      chk("p2_v1", bus.alu_v1, 32'h10);
      step();

      // dispatch bypass on a load
      disp(LW, 3'd5, 3'd4, 3'd0, 32'd0, 32'd0, 32'h100);
      cdb(0, 3'd4, 32'h80);
      step();
      idle();
      step();
      chk("p3_valid", 32'(bus.mem_valid), 32'd1);
      chk("p3_v1", bus.mem_v1, 32'h80);
      chk("p3_imm", bus.mem_imm, 32'h100);
      step();

      // fill ALU side with back-pressure, then drain oldest-first
      bus.alu_ready = 1'b0;
      for (int k = 0; k < AD + 1; k++) begin
         disp(ADD, 3'(k + 1), 3'd0, 3'd0, 32'(k), 32'd0, 32'd0);
         step();
      end
      disp(OR, 3'd7, 3'd0, 3'd0, 32'd0, 32'd0, 32'd0);
      #1;
      chk("p4_full_rdy", 32'(bus.disp_ready), 32'd0);
      step();
      chk("p4_count", 32'(bus.alu_count), 32'(AD));
      chk("p4_hold_des", 32'(bus.alu_des), 32'd1);
      chk("p4_hold_v1", bus.alu_v1, 32'd0);
      idle();
      bus.alu_ready = 1'b1;
      for (int k = 0; k < AD; k++) begin
         step();
         chk("p4_order", 32'(bus.alu_des), 32'(k + 2));
      end
      step();
      chk("p4_empty", 32'(bus.alu_valid), 32'd0);

      // in-order memory: waiting LW blocks a ready SW behind it
      disp(LW, 3'd6, 3'd6, 3'd0, 32'd0, 32'd0, 32'h4);
      step();
      disp(SW, 3'd7, 3'd0, 3'd0, 32'd1, 32'd2, 32'h8);
      step();
      idle();
      for (int k = 0; k < 3; k++) begin
         step();
         chk("p5_blocked", 32'(bus.mem_valid), 32'd0);
      end
      cdb(0, 3'd6, 32'h44);
      step();
      idle();
      step();
      chk("p5_lw_first", 32'(bus.mem_des), 32'd6);
      chk("p5_lw_v1", bus.mem_v1, 32'h44);
      step();
      chk("p5_sw_next", 32'(bus.mem_des), 32'd7);
      chk("p5_sw_valid", 32'(bus.mem_valid), 32'd1);
      step();

      // flush with occupied queue, stalled issue and a same-cycle dispatch
      bus.alu_ready = 1'b0;
      disp(ADD, 3'd1, 3'd0, 3'd0, 32'd1, 32'd1, 32'd0);
      step();
      for (int k = 0; k < 3; k++) begin
         disp(XOR, 3'(k + 2), 3'd7, 3'd0, 32'd0, 32'd0, 32'd0);
         step();
      end
      chk("p6_pre_count", 32'(bus.alu_count), 32'd3);
      chk("p6_pre_valid", 32'(bus.alu_valid), 32'd1);
      bus.flush = 1'b1;
      disp(SUB, 3'd5, 3'd0, 3'd0, 32'd3, 32'd3, 32'd0);
      step();
      chk("p6_count", 32'(bus.alu_count), 32'd0);
      chk("p6_valid", 32'(bus.alu_valid), 32'd0);
      bus.flush = 1'b0;
      idle();
      bus.alu_ready = 1'b1;
      step();
      chk("p6_no_ghost", 32'(bus.alu_valid), 32'd0);

      // random traffic against the model
      for (int n = 0; n < 800; n++) begin
         bus.disp_valid = $urandom_range(0, 3) != 0;
         bus.disp_op = 5'($urandom_range(0, 30));
         bus.disp_des = 3'($urandom_range(0, 7));
         bus.disp_q1 = $urandom_range(0, 1) ? 3'd0 : 3'($urandom_range(1, 7));
         bus.disp_q2 = $urandom_range(0, 2) != 0 ? 3'd0 : 3'($urandom_range(1, 7));
         bus.disp_v1 = $urandom;
         bus.disp_v2 = $urandom;
         bus.disp_imm = $urandom;
         bus.disp_is_branch = 1'($urandom_range(0, 1));
         bus.cdb_valid = 2'($urandom_range(0, 3));
         bus.cdb_tag = 6'($urandom_range(0, 63));
         bus.cdb_data = {$urandom, $urandom};
         bus.alu_ready = $urandom_range(0, 3) != 0;
         bus.mem_ready = $urandom_range(0, 3) != 0;
         bus.flush = $urandom_range(0, 60) == 0;
         step();
      end
      bus.flush = 1'b0;
      idle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
